// File: rtl/feeder_pkg.sv
// Shared widths, state encoding and window-address helper for the im2col feeder.
package feeder_pkg;

   localparam int unsigned DATA_WIDTH   = 8;
   localparam int unsigned B_WIDTH      = 8;
   localparam int unsigned ADDR_WIDTH   = 16;
   localparam int unsigned STREAM_WIDTH = 4;
   localparam int unsigned M            = STREAM_WIDTH;
   localparam int unsigned MEM_DEPTH    = 256;
   localparam int unsigned WORD_WIDTH   = DATA_WIDTH * STREAM_WIDTH;
   localparam int unsigned MEM_AW       = $clog2(MEM_DEPTH);
   localparam int unsigned LOOP_W       = 9;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2,
      DONE  = 2'd3
   } state_e;

   typedef logic [ADDR_WIDTH-1:0] addr_t;

   // Linear RAM address of one im2col element; wraps modulo 2**ADDR_WIDTH.
   function automatic addr_t window_addr(input addr_t oy, input addr_t ox,
                                         input addr_t ky, input addr_t kx,
                                         input addr_t c, input addr_t stride,
                                         input addr_t cols, input addr_t chans);
      return ((oy * stride + ky) * cols + ox * stride + kx) * chans + c;
   endfunction

endpackage

// File: rtl/feeder_ram.sv
// Simple dual-port word RAM: one write port, one registered read port of RD_LAT stages.
module feeder_ram
   import feeder_pkg::*;
#(
   parameter int unsigned RD_LAT = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we_i,
   input  logic [MEM_AW-1:0]     waddr_i,
   input  logic [WORD_WIDTH-1:0] wdata_i,
   input  logic                  re_i,
   input  logic [MEM_AW-1:0]     raddr_i,
   output logic [WORD_WIDTH-1:0] rdata_o
);

   logic [WORD_WIDTH-1:0] mem_q [MEM_DEPTH];
   logic [WORD_WIDTH-1:0] rd1_q;

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // First read stage only advances on a read, so the output holds between reads.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd1_q <= '0;
      end else if (re_i) begin
         rd1_q <= mem_q[raddr_i];
      end
   end

   generate
      if (RD_LAT >= 2) begin : g_lat2
         logic [WORD_WIDTH-1:0] rd2_q;
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               rd2_q <= '0;
            end else begin
               rd2_q <= rd1_q;
            end
         end
         assign rdata_o = rd2_q;
      end else begin : g_lat1
         assign rdata_o = rd1_q;
      end
   endgenerate

endmodule

// File: rtl/feeder.sv
// Input-operand feeder: buffers one feature map, then replays it in im2col window order.
module feeder
   import feeder_pkg::*;
#(
   parameter int unsigned RD_LAT  = 1,
   parameter int unsigned OUT_REG = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  valid_write_i,
   input  logic                  start_i,
   input  logic [WORD_WIDTH-1:0] data_in_i,
   output logic [B_WIDTH-1:0]    data_out_o [M],
   output logic [ADDR_WIDTH-1:0] counter_o,
   output logic [1:0]            state_o,
   output logic                  wr_check_o,
   output logic [7:0]            last_o,
   output logic                  ram_full_o,
   output logic [ADDR_WIDTH-1:0] rd_idx_o,
   input  logic [1:0]            stride_i,
   input  logic [ADDR_WIDTH-1:0] chans_per_mem_i,
   input  logic [ADDR_WIDTH-1:0] in_cols_i,
   output logic                  last_out_o,
   input  logic [ADDR_WIDTH-1:0] k_dimension_i,
   input  logic [ADDR_WIDTH-1:0] o_dimension_i,
   output logic [LOOP_W-1:0]     loop_ctrl_o
);

   localparam int unsigned PIPE = RD_LAT + OUT_REG;

   state_e                state_q;
   addr_t                 counter_q, total_q, rd_idx_q, rd_idx_d;
   addr_t                 stride_q, chans_q, cols_q, k_q, o_q;
   addr_t                 c_q, kx_q, ky_q, ox_q, oy_q;
   addr_t                 c_d, kx_d, ky_d, ox_d, oy_d;
   addr_t                 total_c;
   logic                  ram_full_q, empty_q;
   logic [7:0]            last_q;
   logic [4:0]            wrap_c;
   logic [LOOP_W-1:0]     loop_q;
   logic [PIPE-1:0]       lp_q, lp_d;
   logic                  wr_en_c, issue_c, is_last_c;
   logic [WORD_WIDTH-1:0] rdata, word_out;

   assign total_c   = addr_t'(in_cols_i * in_cols_i * chans_per_mem_i);
   assign wr_en_c   = (state_q == WRITE) && valid_write_i && !ram_full_q;
   assign issue_c   = (state_q == READ) && !empty_q;
   assign is_last_c = wrap_c[4];

   // Loop nest advance: c innermost, then kx, ky, ox, oy.
   always_comb begin
      wrap_c = '0;
      c_d    = c_q;
      kx_d   = kx_q;
      ky_d   = ky_q;
      ox_d   = ox_q;
      oy_d   = oy_q;
      if (issue_c) begin
         wrap_c[0] = (c_q == chans_q - addr_t'(1));
         wrap_c[1] = wrap_c[0] && (kx_q == k_q - addr_t'(1));
         wrap_c[2] = wrap_c[1] && (ky_q == k_q - addr_t'(1));
         wrap_c[3] = wrap_c[2] && (ox_q == o_q - addr_t'(1));
         wrap_c[4] = wrap_c[3] && (oy_q == o_q - addr_t'(1));
         c_d  = wrap_c[0] ? '0 : c_q + addr_t'(1);
         kx_d = wrap_c[1] ? '0 : (wrap_c[0] ? kx_q + addr_t'(1) : kx_q);
         ky_d = wrap_c[2] ? '0 : (wrap_c[1] ? ky_q + addr_t'(1) : ky_q);
         ox_d = wrap_c[3] ? '0 : (wrap_c[2] ? ox_q + addr_t'(1) : ox_q);
         oy_d = wrap_c[4] ? '0 : (wrap_c[3] ? oy_q + addr_t'(1) : oy_q);
      end
   end

   assign rd_idx_d = window_addr(oy_d, ox_d, ky_d, kx_d, c_d, stride_q, cols_q, chans_q);

   // Last-word marker travels with the read data; the final stage is sticky.
   always_comb begin
      lp_d           = PIPE'({lp_q, is_last_c});
      lp_d[PIPE-1]   = lp_d[PIPE-1] | lp_q[PIPE-1];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         counter_q  <= '0;
         total_q    <= '0;
         rd_idx_q   <= '0;
         stride_q   <= '0;
         chans_q    <= '0;
         cols_q     <= '0;
         k_q        <= '0;
         o_q        <= '0;
         c_q        <= '0;
         kx_q       <= '0;
         ky_q       <= '0;
         ox_q       <= '0;
         oy_q       <= '0;
         ram_full_q <= 1'b0;
         empty_q    <= 1'b0;
         last_q     <= '0;
         loop_q     <= '0;
         lp_q       <= '0;
      end else begin
         loop_q <= LOOP_W'(wrap_c);
         lp_q   <= lp_d;
         if (issue_c) begin
            c_q  <= c_d;
            kx_q <= kx_d;
            ky_q <= ky_d;
            ox_q <= ox_d;
            oy_q <= oy_d;
            if (!is_last_c) begin
               rd_idx_q <= rd_idx_d;
            end
         end
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  stride_q   <= (stride_i == 2'd0) ? addr_t'(1) : addr_t'(stride_i);
                  chans_q    <= chans_per_mem_i;
                  cols_q     <= in_cols_i;
                  k_q        <= k_dimension_i;
                  o_q        <= o_dimension_i;
                  total_q    <= total_c;
                  ram_full_q <= (total_c == '0);
                  empty_q    <= (chans_per_mem_i == '0) || (k_dimension_i == '0) ||
                                (o_dimension_i == '0);
                  counter_q  <= '0;
                  rd_idx_q   <= '0;
                  state_q    <= WRITE;
               end
            end
            WRITE: begin
               if (ram_full_q) begin
                  state_q <= READ;
               end else if (wr_en_c) begin
                  counter_q <= counter_q + addr_t'(1);
                  last_q    <= data_in_i[7:0];
                  if (counter_q + addr_t'(1) == total_q) begin
                     ram_full_q <= 1'b1;
                     state_q    <= READ;
                  end
               end
            end
            READ: begin
               if (empty_q || is_last_c) begin
                  state_q <= DONE;
               end
            end
            DONE: begin
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   feeder_ram #(.RD_LAT(RD_LAT)) u_ram (
      .clk     (clk),
      .rst     (rst),
      .we_i    (wr_en_c),
      .waddr_i (MEM_AW'(counter_q)),
      .wdata_i (data_in_i),
      .re_i    (issue_c),
      .raddr_i (MEM_AW'(rd_idx_q)),
      .rdata_o (rdata)
   );

   generate
      if (OUT_REG >= 1) begin : g_oreg
         logic [WORD_WIDTH-1:0] out_q;
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               out_q <= '0;
            end else begin
               out_q <= rdata;
            end
         end
         assign word_out = out_q;
      end else begin : g_nooreg
         assign word_out = rdata;
      end
      for (genvar m = 0; m < M; m++) begin : g_lane
         assign data_out_o[m] = word_out[m*B_WIDTH +: B_WIDTH];
      end
   endgenerate

   assign counter_o   = counter_q;
   assign state_o     = state_q;
   assign wr_check_o  = wr_en_c;
   assign last_o      = last_q;
   assign ram_full_o  = ram_full_q;
   assign rd_idx_o    = rd_idx_q;
   assign last_out_o  = lp_q[PIPE-1];
   assign loop_ctrl_o = loop_q;

endmodule

// File: tb/tb_feeder.sv
// Scenario bench for feeder: random data, reference RAM image and window-order model.
module tb_feeder;
   import feeder_pkg::*;

   localparam int unsigned RD_LAT  = 1;
   localparam int unsigned OUT_REG = 1;
   localparam int          LAT     = RD_LAT + OUT_REG;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  valid_write_i, start_i;
   logic [WORD_WIDTH-1:0] data_in_i;
   logic [B_WIDTH-1:0]    data_out [M];
   logic [ADDR_WIDTH-1:0] counter_o, rd_idx_o;
   logic [1:0]            state_o, stride_i;
   logic                  wr_check_o, ram_full_o, last_out_o;
   logic [7:0]            last_o;
   logic [ADDR_WIDTH-1:0] chans_per_mem_i, in_cols_i, k_dimension_i, o_dimension_i;
   logic [LOOP_W-1:0]     loop_ctrl_o;

   int errors = 0;
   int checks = 0;

   logic [WORD_WIDTH-1:0] exp_mem [MEM_DEPTH];
   logic [ADDR_WIDTH-1:0] obs_idx [$];
   int cfg_cols, cfg_chans, cfg_k, cfg_o, cfg_s;

   feeder #(.RD_LAT(RD_LAT), .OUT_REG(OUT_REG)) dut (
      .clk             (clk),
      .rst             (rst),
      .valid_write_i   (valid_write_i),
      .start_i         (start_i),
      .data_in_i       (data_in_i),
      .data_out_o      (data_out),
      .counter_o       (counter_o),
      .state_o         (state_o),
      .wr_check_o      (wr_check_o),
      .last_o          (last_o),
      .ram_full_o      (ram_full_o),
      .rd_idx_o        (rd_idx_o),
      .stride_i        (stride_i),
      .chans_per_mem_i (chans_per_mem_i),
      .in_cols_i       (in_cols_i),
      .last_out_o      (last_out_o),
      .k_dimension_i   (k_dimension_i),
      .o_dimension_i   (o_dimension_i),
      .loop_ctrl_o     (loop_ctrl_o)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [WORD_WIDTH-1:0] out_word();
      logic [WORD_WIDTH-1:0] w;
      for (int m = 0; m < int'(M); m++) w[m*B_WIDTH +: B_WIDTH] = data_out[m];
      return w;
   endfunction

   task automatic start_run(input int cols, input int chans, input int k, input int o, input int s);
      cfg_cols = cols; cfg_chans = chans; cfg_k = k; cfg_o = o; cfg_s = (s == 0) ? 1 : s;
      in_cols_i       = ADDR_WIDTH'(cols);
      chans_per_mem_i = ADDR_WIDTH'(chans);
      k_dimension_i   = ADDR_WIDTH'(k);
      o_dimension_i   = ADDR_WIDTH'(o);
      stride_i        = 2'(s);
      start_i         = 1'b1;
      tick();
      start_i         = 1'b0;
   endtask

   task automatic hard_reset();
      rst = 1'b1;
      valid_write_i = 1'b0; start_i = 1'b0; data_in_i = '0;
      #2;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Streams the whole map; gap cycles also pulse start with a bogus config.
   task automatic write_all(input bit rnd, input bit gaps);
      int total, n, guard;
      bit vw;
      logic [WORD_WIDTH-1:0] w;
      total = cfg_cols * cfg_cols * cfg_chans;
      n = 0; guard = 0;
      while (n < total && guard < 20 * total + 20) begin
         vw = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         w  = rnd ? WORD_WIDTH'($urandom) : {STREAM_WIDTH{8'(n)}};
         valid_write_i = vw;
         data_in_i     = w;
         start_i       = !vw;
         if (!vw) in_cols_i = ADDR_WIDTH'($urandom_range(1, 9));
         #1;
         checks++;
         if (counter_o !== ADDR_WIDTH'(n))
            $display("FAIL write_counter: got %0d want %0d", counter_o, n);
         checks++;
         if (wr_check_o !== vw)
            $display("FAIL wr_check: got %b want %b at word %0d", wr_check_o, vw, n);
         checks++;
         if (ram_full_o !== 1'b0)
            $display("FAIL ram_full_early: got %b want 0 at word %0d", ram_full_o, n);
         if (wr_check_o !== vw || counter_o !== ADDR_WIDTH'(n) || ram_full_o !== 1'b0) errors++;
         tick();
         if (vw) begin
            exp_mem[n] = w;
            n++;
         end
         guard++;
      end
      valid_write_i = 1'b0;
      start_i = 1'b0;
      checks++;
      if (n != total) begin
         errors++;
         $display("FAIL write_timeout: stored %0d want %0d", n, total);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      valid_write_i = 1'b0; start_i = 1'b0; data_in_i = '0; stride_i = '0;
      chans_per_mem_i = '0; in_cols_i = '0; k_dimension_i = '0; o_dimension_i = '0;
      #3;
      checks++;
      if ({state_o, counter_o, rd_idx_o, last_o, ram_full_o, wr_check_o, last_out_o, loop_ctrl_o} !== '0
          || out_word() !== '0) begin
         errors++;
         $display("FAIL reset_outputs: state=%0d counter=%0d rd_idx=%0d last=%h full=%b last_out=%b loop=%h data=%h want all 0",
                  state_o, counter_o, rd_idx_o, last_o, ram_full_o, last_out_o, loop_ctrl_o, out_word());
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Replays the configured run and compares address, data, last_out and wrap flags.
   task automatic test_readback(input string name);
      int q[$];
      int n, cnt[5], exp_cnt[5];
      logic [WORD_WIDTH-1:0] w;
      for (int oy = 0; oy < cfg_o; oy++)
         for (int ox = 0; ox < cfg_o; ox++)
            for (int ky = 0; ky < cfg_k; ky++)
               for (int kx = 0; kx < cfg_k; kx++)
                  for (int c = 0; c < cfg_chans; c++)
                     q.push_back(((oy * cfg_s + ky) * cfg_cols + ox * cfg_s + kx) * cfg_chans + c);
      n = q.size();
      obs_idx.delete();
      for (int b = 0; b < 5; b++) cnt[b] = 0;
      exp_cnt[0] = n / cfg_chans;
      exp_cnt[1] = exp_cnt[0] / cfg_k;
      exp_cnt[2] = exp_cnt[1] / cfg_k;
      exp_cnt[3] = exp_cnt[2] / cfg_o;
      exp_cnt[4] = 1;
      checks++;
      if (state_o !== 2'd2) begin
         errors++;
         $display("FAIL %s read_entry_state: got %0d want 2", name, state_o);
      end
      for (int k = 0; k < n + LAT; k++) begin
         if (k < n) begin
            obs_idx.push_back(rd_idx_o);
            checks++;
            if (rd_idx_o !== ADDR_WIDTH'(q[k])) begin
               errors++;
               $display("FAIL %s rd_idx[%0d]: got %0d want %0d", name, k, rd_idx_o, q[k]);
            end
         end
         if (k >= LAT) begin
            w = exp_mem[q[k-LAT]];
            checks++;
            if (out_word() !== w) begin
               errors++;
               $display("FAIL %s data_out[%0d]: got %h want %h", name, k - LAT, out_word(), w);
            end
         end
         checks++;
         if (last_out_o !== 1'(k >= n - 1 + LAT)) begin
            errors++;
            $display("FAIL %s last_out cycle %0d: got %b want %b", name, k, last_out_o, k >= n - 1 + LAT);
         end
         for (int b = 0; b < 5; b++) if (loop_ctrl_o[b]) cnt[b]++;
         checks++;
         if (loop_ctrl_o[8:5] !== 4'd0) begin
            errors++;
            $display("FAIL %s loop_ctrl_high: got %h want 0", name, loop_ctrl_o[8:5]);
         end
         tick();
      end
      for (int b = 0; b < 5; b++) begin
         checks++;
         if (cnt[b] != exp_cnt[b]) begin
            errors++;
            $display("FAIL %s loop_wraps bit%0d: got %0d want %0d", name, b, cnt[b], exp_cnt[b]);
         end
      end
      tick();
      tick();
      w = exp_mem[q[n-1]];
      checks++;
      if (state_o !== 2'd3 || last_out_o !== 1'b1 || out_word() !== w) begin
         errors++;
         $display("FAIL %s done_hold: state=%0d last_out=%b data=%h want 3 1 %h",
                  name, state_o, last_out_o, out_word(), w);
      end
   endtask

   task automatic test_write_cfg1();
      start_run(4, 1, 3, 2, 1);
      checks++;
      if (state_o !== 2'd1 || counter_o !== '0 || ram_full_o !== 1'b0) begin
         errors++;
         $display("FAIL cfg1_after_start: state=%0d counter=%0d full=%b want 1 0 0", state_o, counter_o, ram_full_o);
      end
      write_all(1'b0, 1'b0);
      checks++;
      if (counter_o !== 16'd16 || ram_full_o !== 1'b1 || last_o !== 8'h0F || state_o !== 2'd2) begin
         errors++;
         $display("FAIL cfg1_full: counter=%0d full=%b last=%h state=%0d want 16 1 0f 2",
                  counter_o, ram_full_o, last_o, state_o);
      end
      valid_write_i = 1'b1;
      data_in_i = '1;
      #1;
      checks++;
      if (wr_check_o !== 1'b0) begin
         errors++;
         $display("FAIL write_when_full: wr_check got %b want 0", wr_check_o);
      end
      valid_write_i = 1'b0;
   endtask

   task automatic test_stride2();
      hard_reset();
      start_run(5, 1, 3, 2, 2);
      write_all(1'b1, 1'b0);
      test_readback("stride2");
      checks++;
      if (obs_idx[9] !== 16'd2 || obs_idx[18] !== 16'd10) begin
         errors++;
         $display("FAIL stride2_windows: got %0d %0d want 2 10", obs_idx[9], obs_idx[18]);
      end
   endtask

   task automatic test_gaps();
      hard_reset();
      start_run(4, 1, 2, 3, 1);
      write_all(1'b1, 1'b1);
      checks++;
      if (counter_o !== 16'd16 || last_o !== exp_mem[15][7:0]) begin
         errors++;
         $display("FAIL gaps_final: counter=%0d last=%h want 16 %h", counter_o, last_o, exp_mem[15][7:0]);
      end
      test_readback("gaps");
   endtask

   task automatic test_reset_mid_read();
      hard_reset();
      start_run(4, 1, 3, 2, 1);
      write_all(1'b1, 1'b0);
      for (int i = 0; i < 5; i++) tick();
      rst = 1'b1;
      #1;
      checks++;
      if ({state_o, counter_o, rd_idx_o, last_o, ram_full_o, last_out_o, loop_ctrl_o} !== '0
          || out_word() !== '0) begin
         errors++;
         $display("FAIL async_reset: state=%0d counter=%0d rd_idx=%0d full=%b data=%h want all 0",
                  state_o, counter_o, rd_idx_o, ram_full_o, out_word());
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      start_run(4, 1, 3, 2, 1);
      write_all(1'b1, 1'b0);
      test_readback("rerun");
   endtask

   task automatic test_chans2();
      int exp8[8] = '{0, 1, 2, 3, 6, 7, 8, 9};
      hard_reset();
      start_run(3, 2, 2, 2, 1);
      write_all(1'b1, 1'b0);
      checks++;
      if (counter_o !== 16'd18 || ram_full_o !== 1'b1) begin
         errors++;
         $display("FAIL chans2_full: counter=%0d full=%b want 18 1", counter_o, ram_full_o);
      end
      test_readback("chans2");
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (obs_idx[i] !== ADDR_WIDTH'(exp8[i])) begin
            errors++;
            $display("FAIL chans2_order[%0d]: got %0d want %0d", i, obs_idx[i], exp8[i]);
         end
      end
   endtask

   task automatic test_total_zero();
      hard_reset();
      start_run(0, 1, 1, 1, 1);
      checks++;
      if (ram_full_o !== 1'b1 || counter_o !== '0) begin
         errors++;
         $display("FAIL total_zero: full=%b counter=%0d want 1 0", ram_full_o, counter_o);
      end
      hard_reset();
   endtask

   initial begin
      test_reset();
      test_write_cfg1();
      test_readback("cfg1");
      test_stride2();
      test_gaps();
      test_reset_mid_read();
      test_chans2();
      test_total_zero();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/feeder.md
Name: feeder

Overview:
- Input-operand feeder for the systolic matrix engine.
- Phase 1: buffers one input feature map, streamed in as multi-byte words, into an internal RAM.
- Phase 2: replays the buffered data in convolution-window (im2col) order, presenting M byte lanes per cycle to the array's B-side inputs.
- Runs once per start; raises last_out after the final window word.

Parameters:
- RD_LAT, 1: RAM read latency in cycles (1..2).
- OUT_REG, 1: extra output register stages on data_out (0..1).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; clears all state and outputs.
- valid_write  in  1  data_in holds a valid word to store.
- start  in  1  begin operation.
- data_in  in  DATA_WIDTH*STREAM_WIDTH  input word; lane u occupies bits [(u+1)*8-1 : u*8].
- data_out  out  M x B_WIDTH  unpacked lane array; lane m is byte m of the replayed word.
- counter  out  ADDR_WIDTH  write address = number of words stored.
- state  out  2  FSM state.
- wr_check  out  1  RAM write strobe for the current cycle.
- last  out  8  lane-0 byte of the most recently stored word.
- ram_full  out  1  all required words stored.
- rd_idx  out  ADDR_WIDTH  current RAM read address.
- stride  in  2  convolution stride; 0 treated as 1.
- chans_per_mem  in  ADDR_WIDTH  channel words per pixel (channels / STREAM_WIDTH).
- In_cols  in  ADDR_WIDTH  input width = input height.
- last_out  out  1  final window word is on data_out.
- k_dimension  in  ADDR_WIDTH  kernel size K.
- o_dimension  in  ADDR_WIDTH  output size O.
- loop_ctrl  out  9  loop wrap flags.

Interface decisions (already decided): one clock, clk; rst is asynchronous and active-high.

Behaviour:
- Reset: all outputs 0, state IDLE, loop counters 0. RAM contents are not cleared.
- FSM encoding: IDLE=0, WRITE=1, READ=2, DONE=3.
- IDLE: when start=1, capture stride, chans_per_mem, In_cols, k_dimension, o_dimension; compute TOTAL = In_cols*In_cols*chans_per_mem; go to WRITE.
- WRITE:
  - Each cycle with valid_write=1 and ram_full=0: store data_in at address counter; wr_check=1 that cycle; counter increments.
  - last is updated to data_in[7:0] on each store.
  - When counter reaches TOTAL: ram_full=1 on the next cycle, held until reset; state goes to READ.
  - While ram_full=1, writes are ignored and wr_check stays 0.
  - valid_write=0 pauses the write with no side effect.
- READ: nested loops, innermost first: c over 0..chans_per_mem-1, kx over 0..K-1, ky over 0..K-1, ox over 0..O-1, oy over 0..O-1.
  - rd_idx = ((oy*stride+ky)*In_cols + ox*stride+kx)*chans_per_mem + c.
  - One address is issued per cycle, starting the cycle after ram_full rises.
- Read data path:
  - data_out is updated RD_LAT+OUT_REG cycles after the address is issued.
  - data_out[m] = stored byte lane m.
  - Requirement: M == STREAM_WIDTH.
- loop_ctrl flags:
  - Bits: bit0 c wrap, bit1 kx wrap, bit2 ky wrap, bit3 ox wrap, bit4 oy wrap; bits 8:5 = 0.
  - Each flag is high in the cycle its counter wraps.
- End of READ:
  - After the final address (O*O*K*K*chans_per_mem reads), go to DONE.
  - last_out is asserted in the same cycle the final word appears on data_out and held until reset.
  - data_out holds its last value.
- Arithmetic: address math is ADDR_WIDTH unsigned; configurations whose addresses overflow are illegal.
- Boundary conditions:
  - start is ignored outside IDLE.
  - Reset mid-operation returns to IDLE immediately.
  - TOTAL=0 leads to ram_full in the cycle after start.

Decomposition:
- Shared package: DATA_WIDTH=8, B_WIDTH=8, ADDR_WIDTH=16, STREAM_WIDTH, M, MEM_DEPTH, and the state enum.
- Sub-module feeder_ram: simple dual-port RAM of width DATA_WIDTH*STREAM_WIDTH and depth MEM_DEPTH, with one write port and one registered read port.

Test Plan:
- Common configuration for the first two tests: In_cols=4, chans_per_mem=1, K=3, O=2, stride=1, M=STREAM_WIDTH=4.
- Write word n = {4{n[7:0]}} for n=0..15 -> counter reaches 16; ram_full=1 one cycle after the 16th write; last=0x0F; state=READ.
- Readback of the same configuration:
  - lane-0 sequence is 0,1,2,4,5,6,8,9,10, then 1,2,3,5,6,7,9,10,11, then 4..14 and 5..15 in the same window pattern (36 words);
  - last_out=1 with the 36th word.
- stride=2, In_cols=5, K=3, O=2 -> the second window starts at address 2; the third window starts at address 10.
- valid_write toggled 1,0,1 -> counter increments only on high cycles; no gaps or duplicates in stored data.
- rst asserted during READ -> all outputs 0 asynchronously; a new start re-runs the sequence with no stale last_out.
- chans_per_mem=2, In_cols=3, K=2, O=2 -> first window address order: 0,1,2,3,6,7,8,9; ram_full after 18 writes.
